// File: rtl/led_frame_streamer.sv
// led_frame_streamer: APB3 slave holding a GRB pixel frame buffer and the
// control/status registers that sequence it. On START it streams the first
// min(LEN, NUM_LEDS) pixels in index order over valid/ready to the WS2812
// bit encoder, then raises a sticky DONE flag that can drive an interrupt.
module led_frame_streamer #(
    parameter int NUM_LEDS = 64,
    parameter int IDX_W    = 6
) (
    input  logic        PCLK,
    input  logic        PRESERN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic        pix_last,
    input  logic        pix_ready,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        DONE_ST = 2'd2
    } state_t;

    localparam logic [7:0] MAX_LEN = 8'(NUM_LEDS);

    // Clamp the programmed LEN to the buffer depth.
    function automatic logic [7:0] eff_len(input logic [7:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    // Architectural state
    state_t           state_q;
    logic [23:0]      buf_q [NUM_LEDS];
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_idx_q;
    logic             busy_q;
    logic             done_q;
    logic             auto_q;
    logic             irq_en_q;
    logic [7:0]       len_q;
    logic [23:0]      pix_data_q;
    logic             pix_valid_q;
    logic             pix_last_q;
    logic [31:0]      prdata_q;

    // APB decode
    logic             wr_en;
    logic             rd_setup;
    logic [5:0]       word;
    logic             pix_hit;
    logic             ctrl_wr;
    logic             status_wr;
    logic             irq_en_wr;
    logic             start_req;
    logic [31:0]      rd_data;

    // Frame sequencing helpers
    logic             frame_go;
    logic [7:0]       go_len;
    logic [IDX_W-1:0] idx_nxt;

    // Address bits and data bits that no register looks at.
    logic             unused_bits;
    assign unused_bits = ^{PADDR[31:9], PADDR[1:0], PWDATA[31:24]};

    assign wr_en     = PSEL & PENABLE & PWRITE;
    assign rd_setup  = PSEL & ~PENABLE & ~PWRITE;
    assign word      = PADDR[7:2];
    assign pix_hit   = PADDR[8] & (int'(word) < NUM_LEDS);
    assign ctrl_wr   = wr_en & ~PADDR[8] & (word == 6'd0);
    assign status_wr = wr_en & ~PADDR[8] & (word == 6'd1);
    assign irq_en_wr = wr_en & ~PADDR[8] & (word == 6'd2);
    assign start_req = ctrl_wr & PWDATA[0];
    assign idx_nxt   = idx_q + IDX_W'(1);

    // A frame starts on START from IDLE (LEN taken from the same write) or on
    // an AUTO restart out of DONE_ST (LEN re-sampled from the register).
    assign frame_go = ((state_q == IDLE) && start_req) || ((state_q == DONE_ST) && auto_q);
    assign go_len   = eff_len((state_q == IDLE) ? PWDATA[15:8] : len_q);

    // Read mux for the APB setup phase.
    // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_data = '0;
        if (PADDR[8]) begin
            if (pix_hit) begin
                rd_data = {8'h0, buf_q[word]};
            end
        end else begin
            case (word)
                6'd0:    rd_data = {16'h0, len_q, 6'h0, auto_q, 1'b0};
                6'd1:    rd_data = {16'h0, 8'(idx_q), 6'h0, done_q, busy_q};
                6'd2:    rd_data = {31'h0, irq_en_q};
                default: rd_data = '0;
            endcase
        end
    end

    // Read data is captured in the setup cycle and held through the access cycle.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            prdata_q <= '0;
        end else if (rd_setup) begin
            prdata_q <= rd_data;
        end
    end

    // Software-visible configuration registers.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            auto_q   <= 1'b0;
            len_q    <= '0;
            irq_en_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                auto_q <= PWDATA[1];
                len_q  <= PWDATA[15:8];
            end
            if (irq_en_wr) begin
                irq_en_q <= PWDATA[0];
            end
        end
    end

    // Sticky DONE: set on every pass through DONE_ST, W1C otherwise; set wins.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            done_q <= 1'b0;
        end else if (state_q == DONE_ST) begin
            done_q <= 1'b1;
        end else if (status_wr && PWDATA[1]) begin
            done_q <= 1'b0;
        end
    end

    // Pixel buffer: APB writes, cleared on reset so a fresh frame sends black.
    // NOTE: this buffer is deliberately reset; storage that need not be cleared is normally left unreset.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (wr_en && pix_hit) begin
            buf_q[word] <= PWDATA[23:0];
        end
    end

    // Frame sequencer with registered stream outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESERN) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            idx_q       <= '0;
            last_idx_q  <= '0;
            pix_data_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
        end else if (frame_go) begin
            busy_q     <= 1'b1;
            idx_q      <= '0;
            last_idx_q <= IDX_W'(go_len - 8'd1);
            pix_data_q <= buf_q[0];
            pix_last_q <= (go_len == 8'd1);
            if (go_len != 8'd0) begin
                pix_valid_q <= 1'b1;
                state_q     <= SEND;
            end else begin
                state_q <= DONE_ST;
            end
        end else begin
            case (state_q)
                SEND: begin
                    if (pix_valid_q && pix_ready) begin
                        if (pix_last_q) begin
                            pix_valid_q <= 1'b0;
                            pix_last_q  <= 1'b0;
                            state_q     <= DONE_ST;
                        end else begin
                            idx_q      <= idx_nxt;
                            pix_data_q <= buf_q[idx_nxt];
                            pix_last_q <= (idx_nxt == last_idx_q);
                        end
                    end
                end
                DONE_ST: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign PRDATA    = prdata_q;
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign irq       = done_q & irq_en_q;

endmodule

// File: doc/led_frame_streamer.md
Name: led_frame_streamer

Overview:
- APB3 slave holding a pixel frame buffer of NUM_LEDS 24-bit GRB words, plus control/status registers.
- On software START, streams the first LEN pixels in index order over a valid/ready interface to the downstream WS2812 bit encoder.
- Sits directly upstream of the encoder. The encoder owns bit timing and the latch/reset gap; this block owns frame storage, sequencing and the frame-done interrupt.

Parameters:
- NUM_LEDS, 64, pixel buffer depth (1..64).
- IDX_W, 6, index/count width; must hold NUM_LEDS-1.

Ports:
- PCLK  in  1  clock
- PRESERN  in  1  synchronous active-low reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  APB write
- PADDR  in  32  APB address; only [8:2] decoded
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- pix_data  out  24  pixel to encoder, GRB, bit 23 first on wire
- pix_valid  out  1  pix_data valid
- pix_last  out  1  current pixel is last of frame
- pix_ready  in  1  encoder accepts pixel
- irq  out  1  level interrupt = DONE & IRQ_EN

Behaviour:
- Reset (PRESERN=0 at PCLK edge): pix_valid=0, pix_last=0, pix_data=0, PRDATA=0, irq=0, all registers 0, pixel buffer cleared to 0, FSM=IDLE. Reset mid-frame aborts the frame; pix_valid low after that edge, no DONE.
- APB write: commits when PSEL&PENABLE&PWRITE. Zero wait states.
- APB read: PRDATA registered in setup cycle (PSEL&~PENABLE&~PWRITE); valid during access cycle.
- Register map (byte offsets, PADDR[8]=0):
  - 0x00 CTRL: [0] START (write-1 pulse, reads 0), [1] AUTO, [15:8] LEN.
  - 0x04 STATUS: [0] BUSY (RO), [1] DONE (sticky, write-1-to-clear), [15:8] current index (RO).
  - 0x08 IRQ_EN: [0].
  - Other offsets with PADDR[8]=0 read 0; writes ignored.
- Pixel region (PADDR[8]=1): index = PADDR[7:2].
  - Writes PWDATA[23:0]; reads {8'h0, pixel}.
  - Index >= NUM_LEDS: write ignored, read 0.
  - Pixel writes are accepted while BUSY; an index not yet loaded into pix_data sends the new value.
- Effective length: L = min(LEN, NUM_LEDS).
- FSM states IDLE, SEND, DONE_ST.
- IDLE:
  - START written with L>0: load pix_data=buf[0], pix_valid=1, pix_last=(L==1), idx=0, BUSY=1; go to SEND. pix_valid is high the cycle after the APB access cycle.
  - START with L=0: DONE set next cycle, no transfer.
- SEND:
  - Transfer occurs when pix_valid&pix_ready.
  - pix_data/pix_last held stable while valid&~ready.
  - On a transfer of a non-last pixel: next edge presents buf[idx+1], idx increments, no bubble.
  - On a transfer of the last pixel: pix_valid=0, pix_last=0; go to DONE_ST.
- DONE_ST (1 cycle): DONE=1.
  - AUTO=1: restart at pixel 0 (pix_valid next cycle) with LEN re-sampled. BUSY stays 1.
  - AUTO=0: BUSY=0; go to IDLE.
- START while BUSY: ignored, with no error. Clearing AUTO mid-frame ends after the current frame.
- Simultaneous DONE set and W1C clear in the same cycle: set wins.
- irq is combinational from registered DONE and IRQ_EN.
- LEN/CTRL writes while BUSY update the register; they take effect at the next frame start only.

Test Plan:
- Reset, read 0x04 and pixel 0x100 -> both 0; pix_valid=0; irq=0.
- Write pixels 0..2 = 0x00FF00, 0x0000FF, 0xFF0000. CTRL=0x0301. pix_ready=1 constantly -> pix_valid high 3 consecutive cycles starting the cycle after the write, data in that order, pix_last only on the third; DONE=1 two cycles after the last transfer window; BUSY=0.
- Same frame with pix_ready toggling 1-cycle-on/2-off -> each pixel held stable until accepted; exactly 3 transfers; STATUS index reads 1 mid-frame.
- IRQ_EN=1, frame LEN=1 -> irq rises with DONE. Write 0x04=0x2 -> irq falls next cycle. Write START with LEN=0 -> DONE without any pix_valid.
- AUTO=1, LEN=2, START -> repeated frames 0,1,0,1…; clear AUTO during frame -> stops after that frame. START while BUSY -> no extra frame.
- LEN=200 with NUM_LEDS=64 -> exactly 64 transfers. Write pixel index 70 -> read back 0. Assert PRESERN=0 mid-frame -> pix_valid=0 next edge, buffer reads 0, DONE=0.
